// File: rtl/acc_addsub_4.sv
// rtl/acc_addsub_4.sv - registered two's-complement add/sub accumulator with overflow history
//
// Ports:
//   CLK, nRST              clock, synchronous active-low reset
//   IN_VALID/IN_READY      operation handshake; OP selects add/sub/load/clear, D is the operand
//   OUT_VALID/OUT_READY    result handshake for ACC/CO/OVF
//   ACC, CO, OVF           accumulator, carry-out (subtract: 1 = no borrow), signed overflow
//   OVF_STICKY, OVF_CNT    overflow history, saturating counter
//   STICKY_CLR             clears overflow history
module acc_addsub_4 #(
    parameter int WIDTH = 4,
    parameter int SAT   = 0,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ACC,
    output logic             CO,
    output logic             OVF,
    output logic             OVF_STICKY,
    output logic [CNT_W-1:0] OVF_CNT,
    input  logic             STICKY_CLR
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0]       OP_ADD  = 2'b00;
    localparam logic [1:0]       OP_SUB  = 2'b01;
    localparam logic [1:0]       OP_LOAD = 2'b10;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             is_arith;
    logic             cin;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] low_sum;
    logic [WIDTH:0]   full_sum;
    logic             c_msb;
    logic             c_out;
    logic             ovf_raw;
    logic [WIDTH-1:0] res_acc;
    logic             res_co;
    logic             res_ovf;

    assign OUT_VALID = (state == FULL);
    assign IN_READY  = !OUT_VALID || OUT_READY;
    assign accept    = IN_VALID && IN_READY;
    assign is_arith  = (OP == OP_ADD) || (OP == OP_SUB);

    // Subtract reuses the adder: invert the operand and inject carry-in of 1.
    assign cin  = (OP == OP_SUB);
    assign b_op = (OP == OP_SUB) ? ~D : D;

    // The low-bits sum exposes the carry into the MSB for overflow detection.
    assign low_sum  = {1'b0, ACC[WIDTH-2:0]} + {1'b0, b_op[WIDTH-2:0]}
                    + {{(WIDTH-1){1'b0}}, cin};
    assign full_sum = {1'b0, ACC} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    assign c_msb    = low_sum[WIDTH-1];
    assign c_out    = full_sum[WIDTH];
    assign ovf_raw  = c_msb ^ c_out;

    always_comb begin
        res_acc = '0;
        res_co  = 1'b0;
        res_ovf = 1'b0;
        case (OP)
            OP_ADD, OP_SUB: begin
                res_co  = c_out;
                res_ovf = ovf_raw;
                // Clamp direction follows the old sign: overflow can only push
                // a value past the end it was already on.
                if ((SAT != 0) && ovf_raw) begin
                    res_acc = ACC[WIDTH-1] ? MAX_NEG : MAX_POS;
                end else begin
                    res_acc = full_sum[WIDTH-1:0];
                end
            end
            OP_LOAD: begin
                res_acc = D;
            end
            default: begin
                res_acc = '0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (OUT_READY) begin
                    state_nxt = EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ACC <= '0;
            CO  <= 1'b0;
            OVF <= 1'b0;
        end else if (accept) begin
            ACC <= res_acc;
            CO  <= res_co;
            OVF <= res_ovf;
        end
    end

    // A new overflow event beats a simultaneous clear so it is never lost.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            OVF_STICKY <= 1'b0;
            OVF_CNT    <= '0;
        end else if (accept && is_arith && ovf_raw) begin
            OVF_STICKY <= 1'b1;
            if (STICKY_CLR) begin
                OVF_CNT <= CNT_ONE;
            end else if (OVF_CNT != CNT_MAX) begin
                OVF_CNT <= OVF_CNT + CNT_ONE;
            end
        end else if (STICKY_CLR) begin
            OVF_STICKY <= 1'b0;
            OVF_CNT    <= '0;
        end
    end

endmodule

// File: doc/acc_addsub_4.md
Name: acc_addsub_4

Overview:
- Registered accumulator stage wrapped around the 4-bit two's-complement add/subtract unit with overflow detection.
- Accepts a stream of operations (add, subtract, load, clear) over a valid/ready handshake and applies each one to the accumulator.
- Registers the result together with its carry and overflow flags.
- Tracks overflow history (sticky flag plus saturating counter) for the downstream consumer.
- Optionally saturates the accumulator on signed overflow.

Parameters:
- WIDTH, 4, accumulator/operand width in bits (two's complement).
- SAT, 0, 1 = clamp accumulator to most positive/negative value on overflow; 0 = wrap.
- CNT_W, 4, width of overflow event counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  synchronous active-low reset.
- IN_VALID  input  1  operation present on OP/D.
- IN_READY  output  1  stage can accept an operation this cycle.
- OP  input  2  00 add, 01 subtract, 10 load D, 11 clear.
- D  input  WIDTH  operand.
- OUT_VALID  output  1  ACC/CO/OVF hold a result not yet consumed.
- OUT_READY  input  1  consumer takes the result this cycle.
- ACC  output  WIDTH  accumulator value.
- CO  output  1  carry-out of the last add/sub (for subtract, 1 = no borrow).
- OVF  output  1  signed overflow of the last add/sub.
- OVF_STICKY  output  1  set by any overflow since reset/clear.
- OVF_CNT  output  CNT_W  number of overflows, saturates at all-ones.
- STICKY_CLR  input  1  clears OVF_STICKY and OVF_CNT.

Behaviour:
- Reset (nRST=0 at a CLK edge): ACC=0, CO=0, OVF=0, OUT_VALID=0, OVF_STICKY=0, OVF_CNT=0, FSM→EMPTY. Any result in flight is discarded. Reset has priority over all other inputs.
- FSM has two states:
  - EMPTY (OUT_VALID=0).
  - FULL (OUT_VALID=1).
- IN_READY = !OUT_VALID | OUT_READY, combinational. Full throughput: one operation per cycle when OUT_READY is held high.
- An operation is accepted when IN_VALID & IN_READY at a CLK edge. Its result appears on ACC/CO/OVF at that edge, so latency is 1 cycle, and OUT_VALID=1 after it.
- FULL & OUT_READY & no accept → EMPTY. FULL & accept → stay FULL with new result. EMPTY & accept → FULL.
- While OUT_VALID=1 & OUT_READY=0: ACC, CO, OVF, OUT_VALID are frozen. IN_READY=0, and IN_VALID is ignored.
- Add: sum = ACC + D + 0.
- Subtract: sum = ACC + ~D + 1, computed on the same adder (operand inverted, carry-in = 1).
- Flags for add/sub:
  - CO = carry out of bit WIDTH-1.
  - OVF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Register update for add/sub:
  - SAT=0: ACC ← sum[WIDTH-1:0].
  - SAT=1 & OVF: ACC ← 0111…1 if the old ACC MSB=0, else 1000…0.
- Load: ACC ← D, CO ← 0, OVF ← 0.
- Clear: ACC ← 0, CO ← 0, OVF ← 0.
- Overflow history: on an accepted add/sub with OVF=1, OVF_STICKY ← 1 and OVF_CNT ← OVF_CNT+1. OVF_CNT holds at all-ones and never wraps.
- STICKY_CLR=1 clears OVF_STICKY and OVF_CNT, independent of the handshake.
  - If STICKY_CLR coincides with an accepted overflowing op, the new event wins: OVF_STICKY=1, OVF_CNT=1.
- Load and clear never affect OVF_STICKY or OVF_CNT.
- OP values are fully decoded; no illegal codes.

Test Plan:
1. Reset, then load 0111, then add 0001 (SAT=0), OUT_READY=1 → ACC=1000, CO=0, OVF=1, OVF_STICKY=1, OVF_CNT=1, OUT_VALID=1 one cycle after each accept.
2. SAT=1 instance, same sequence → ACC=0111, OVF=1. Then load 1000 and subtract 0001 → ACC=1000 (clamped), CO=1, OVF=1, OVF_CNT=2.
3. Load 0011, subtract 0011 → ACC=0000, CO=1, OVF=0. Then subtract 0001 → ACC=1111, CO=0, OVF=0, OVF_STICKY unchanged.
4. Backpressure: OUT_READY=0 after one accepted add, IN_VALID held high for 3 cycles → IN_READY=0, ACC/flags frozen. Raise OUT_READY → next op accepted in that same cycle, new result on the following edge.
5. STICKY_CLR asserted in the same cycle as an accepted 0111+0001 while OVF_CNT=3 → OVF_STICKY=1, OVF_CNT=1. STICKY_CLR alone next cycle → OVF_STICKY=0, OVF_CNT=0.
6. nRST=0 while FULL with OUT_READY=0 and IN_VALID=1 → next edge: all outputs 0, OUT_VALID=0, IN_READY=1. 16 overflows with CNT_W=4 → OVF_CNT=1111 (holds, does not wrap).
